// File: rtl/dmux4way16_pkg.sv
// rtl/dmux4way16_pkg.sv - shared constants for the 4-way 16-bit router
package dmux4way16_pkg;
    localparam int NUM_CH    = 4;
    localparam int CH_A      = 0;
    localparam int CH_B      = 1;
    localparam int CH_C      = 2;
    localparam int CH_D      = 3;
    localparam int STAT_W    = 16;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;
endpackage

// File: rtl/dmux_chan_fifo.sv
// rtl/dmux_chan_fifo.sv - per-channel FIFO; push ignored when full, pop ignored when empty
module dmux_chan_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked by the top while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/dmux4way16_router.sv
// rtl/dmux4way16_router.sv - 1-to-4 buffered word router; pop counters built under DMUX4_STATS_EN
module dmux4way16_router
    import dmux4way16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NUM_CH*WIDTH-1:0]    out_data,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*STAT_W-1:0]   stat_cnt
);
    logic [NUM_CH-1:0] full, empty, push, pop;
    logic [WIDTH-1:0]  head [NUM_CH];

    // Readiness follows only the selected channel's fullness, never out_ready.
    assign in_ready = ~full[in_sel];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign push[ch]      = in_valid & in_ready & (in_sel == 2'(ch));
        assign out_valid[ch] = ~empty[ch];
        assign pop[ch]       = out_valid[ch] & out_ready[ch];
        assign out_data[ch*WIDTH +: WIDTH] = out_valid[ch] ? head[ch] : '0;

        dmux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[ch]),
            .pop       (pop[ch]),
            .push_data (in_data),
            .head_data (head[ch]),
            .full      (full[ch]),
            .empty     (empty[ch])
        );

`ifdef DMUX4_STATS_EN
        logic [STAT_W-1:0] stat_q, stat_d;

        assign stat_d = pop[ch] ? stat_q + 1'b1 : stat_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stat_q <= '0;
            else        stat_q <= stat_d;
        end

        assign stat_cnt[ch*STAT_W +: STAT_W] = stat_q;
`endif
    end

`ifndef DMUX4_STATS_EN
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_dmux4way16_router.sv
// tb/tb_dmux4way16_router.sv - scoreboard bench for dmux4way16_router
module tb_dmux4way16_router;
    typedef struct {
        logic [15:0] d;
        int          acc;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] stat_cnt;

    ent_t        exp_q [4][$];
    int          last_pop [4];
    logic [15:0] stat_m [4];
    int          cyc;
    int          errors;
    int          checks;

    dmux4way16_router #(.WIDTH(16), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stat_cnt  (stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %h expected %h (cycle %0d)", nm, ch, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_stat(input int ch);
`ifdef DMUX4_STATS_EN
        return stat_m[ch];
`else
        return (ch < 0) ? stat_m[0] : 16'h0000;
`endif
    endfunction

    // Monitor: compares each channel's head against the scoreboard every mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int ch = 0; ch < 4; ch++) begin
                automatic logic        v = out_valid[ch];
                automatic logic [15:0] d = out_data[ch*16 +: 16];
                automatic int          vis;
                chk("stat_cnt", ch, 32'(stat_cnt[ch*16 +: 16]), 32'(exp_stat(ch)));
                if (!v) chk("zero_data", ch, 32'(d), 32'h0);
                if (exp_q[ch].size() == 0) begin
                    chk("idle_valid", ch, 32'(v), 32'h0);
                end else begin
                    vis = exp_q[ch][0].acc + 1;
                    if (last_pop[ch] + 1 > vis) vis = last_pop[ch] + 1;
                    if (cyc >= vis) begin
                        chk("head_valid", ch, 32'(v), 32'h1);
                        chk("head_data", ch, 32'(d), 32'(exp_q[ch][0].d));
                        if (v && out_ready[ch]) begin
                            void'(exp_q[ch].pop_front());
                            last_pop[ch] = cyc;
                            stat_m[ch]   = stat_m[ch] + 16'h1;
                        end
                    end else begin
                        chk("early_valid", ch, 32'(v), 32'h0);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d,
                         input logic [3:0] r, output logic rdy_seen);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        rdy_seen = in_ready;
        if (v && in_ready) exp_q[s].push_back('{d, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, 0, 32'(out_valid), 32'h0);
        chk({nm, "_data_lo"}, 0, out_data[31:0], 32'h0);
        chk({nm, "_data_hi"}, 0, out_data[63:32], 32'h0);
        chk({nm, "_stat_lo"}, 0, stat_cnt[31:0], 32'h0);
        chk({nm, "_stat_hi"}, 0, stat_cnt[63:32], 32'h0);
        chk({nm, "_in_ready"}, 0, 32'(in_ready), 32'h1);
    endtask

    task automatic flush_model();
        for (int ch = 0; ch < 4; ch++) begin
            exp_q[ch].delete();
            last_pop[ch] = -10;
            stat_m[ch]   = 16'h0;
        end
    endtask

    initial begin
        logic r;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'b10;
        in_data   = 16'h0;
        out_ready = 4'b0000;
        flush_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst_n = 1'b1;

        // Single word to ch1, held.
        drive(1'b1, 2'b01, 16'hE1D8, 4'b0000, r);
        chk("push_e1d8_ready", 1, 32'(r), 32'h1);
        drive(1'b0, 2'b01, 16'h0, 4'b0000, r);
        chk("ch1_only_valid", 1, 32'(out_valid), 32'h2);
        drive(1'b0, 2'b01, 16'h0, 4'b0010, r);

        // Fill ch2, verify back-pressure and single-pop recovery.
        drive(1'b1, 2'b10, 16'h1111, 4'b0000, r);
        drive(1'b1, 2'b10, 16'h2222, 4'b0000, r);
        drive(1'b1, 2'b10, 16'h3333, 4'b0000, r);
        chk("ch2_full_ready", 2, 32'(r), 32'h0);
        drive(1'b0, 2'b10, 16'h0, 4'b0100, r);
        drive(1'b0, 2'b10, 16'h0, 4'b0000, r);
        chk("ch2_after_pop_ready", 2, 32'(r), 32'h1);
        drive(1'b0, 2'b10, 16'h0, 4'b0100, r);

        // Full ch3 with simultaneous pop and push: push refused, then accepted.
        drive(1'b1, 2'b11, 16'h3A01, 4'b0000, r);
        drive(1'b1, 2'b11, 16'h3A02, 4'b0000, r);
        drive(1'b1, 2'b11, 16'h3A03, 4'b1000, r);
        chk("ch3_full_pop_ready", 3, 32'(r), 32'h0);
        drive(1'b1, 2'b11, 16'h3A03, 4'b0000, r);
        chk("ch3_retry_ready", 3, 32'(r), 32'h1);
        repeat (3) drive(1'b0, 2'b11, 16'h0, 4'b1000, r);

        // Back-to-back across all channels, consumers always ready.
        drive(1'b1, 2'b00, 16'hAAAA, 4'b1111, r);
        chk("b2b_a_ready", 0, 32'(r), 32'h1);
        drive(1'b1, 2'b01, 16'hBBBB, 4'b1111, r);
        chk("b2b_b_ready", 1, 32'(r), 32'h1);
        drive(1'b1, 2'b10, 16'hCCCC, 4'b1111, r);
        chk("b2b_c_ready", 2, 32'(r), 32'h1);
        drive(1'b1, 2'b11, 16'hDDDD, 4'b1111, r);
        chk("b2b_d_ready", 3, 32'(r), 32'h1);
        repeat (2) drive(1'b0, 2'b00, 16'h0, 4'b1111, r);

        // Streaming into ch0 with a ready consumer: one word per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 16'h5000 + 16'(i), 4'b0001, r);
            chk("stream_ready", 0, 32'(r), 32'h1);
        end
        repeat (2) drive(1'b0, 2'b00, 16'h0, 4'b0001, r);
`ifdef DMUX4_STATS_EN
        chk("ch0_pop_count", 0, 32'(stat_cnt[15:0]), 32'd5);
`else
        chk("ch0_pop_count", 0, 32'(stat_cnt[15:0]), 32'd0);
`endif

        // Reset while words are buffered: everything is discarded at once.
        drive(1'b1, 2'b00, 16'h7777, 4'b0000, r);
        drive(1'b1, 2'b10, 16'h8888, 4'b0000, r);
        drive(1'b1, 2'b10, 16'h9999, 4'b0000, r);
        in_valid = 1'b0;
        in_sel   = 2'b10;
        chk("pre_rst_full", 2, 32'(in_ready), 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        flush_model();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 2'b00, 16'h0, 4'b1111, r);
        drive(1'b1, 2'b10, 16'h4242, 4'b0000, r);
        chk("post_rst_ready", 2, 32'(r), 32'h1);
        repeat (2) drive(1'b0, 2'b10, 16'h0, 4'b0100, r);

        for (int ch = 0; ch < 4; ch++)
            chk("queue_drained", ch, 32'(exp_q[ch].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmux4way16_router.md
DMUX4WAY16_ROUTER -- requirements
Module: dmux4way16_router

Interface
REQ-001 Parameter WIDTH, default 16: word width of input and of each output channel.
REQ-002 Parameter DEPTH, default 2: entries per output-channel FIFO; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  word offered for routing.
REQ-006 in_sel  input  2  destination: 00->a (ch0), 01->b (ch1), 10->c (ch2), 11->d (ch3).
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  router accepts the offered word this cycle.
REQ-009 out_data  output  4*WIDTH  per-channel head word; ch i at bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  output  4  per-channel head word valid.
REQ-011 out_ready  input  4  per-channel consumer accepts head word.
REQ-012 stat_cnt  output  64  per-channel delivered-word counters; ch i at bits [i*16 +: 16].

Function
REQ-013 in_ready SHALL equal NOT full[in_sel], combinational on in_sel only; no dependence on out_ready.
REQ-014 Accept = in_valid AND in_ready; accepted word SHALL be written to FIFO in_sel at that rising edge.
REQ-015 out_valid[i] SHALL equal NOT empty[i]; latency acceptance-edge to out_valid = 1 cycle.
REQ-016 Pop = out_valid[i] AND out_ready[i]; head advances at that edge; channels pop independently, up to 4 per cycle.
REQ-017 out_data for channel i SHALL be its FIFO head when out_valid[i]=1, all zeros when out_valid[i]=0.
REQ-018 Per-channel order SHALL be FIFO; no ordering guaranteed across channels.
REQ-019 Full channel with simultaneous pop and offered push: push refused (in_ready=0), pop performed; no pass-through.
REQ-020 Empty channel: no pop possible; push with out_ready=1 still yields 1-cycle latency, no bypass.
REQ-021 Read/write pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH+1), never exceeds DEPTH or underflows.
REQ-022 Upstream SHALL hold in_data/in_sel stable while in_valid AND NOT in_ready; router SHALL hold out_data[i] stable while out_valid[i] AND NOT out_ready[i].
REQ-023 Throughput: one accepted word per cycle while target channel is not full.

Reset
REQ-024 rst_n=0 SHALL immediately, without clock: empty all FIFOs, zero pointers/counts, out_valid=4'b0000, out_data=0, stat_cnt=0.
REQ-025 During and after reset in_ready SHALL be 1 (all channels empty).
REQ-026 Reset asserted mid-transfer SHALL discard all buffered words; no partial word delivered after release.
REQ-027 Deassertion SHALL be synchronized to clk externally; first state update on first rising edge after release.

Configuration
REQ-028 Macro DMUX4_STATS_EN defined: stat_cnt ch i SHALL increment by 1 on each pop of ch i, 16-bit, wrapping 16'hFFFF->0.
REQ-029 Macro DMUX4_STATS_EN undefined: counters not built, stat_cnt port kept and tied to 0; all other behaviour identical.

Structure
REQ-030 Package dmux4way16_pkg SHALL hold channel index constants CH_A..CH_D (0..3), NUM_CH=4, STAT_W=16, default WIDTH/DEPTH.
REQ-031 Sub-module dmux_chan_fifo (WIDTH, DEPTH; push, pop, data in/out, full, empty) SHALL be instantiated four times; top holds only select decode, in_ready mux, output zeroing and stats.

Verification
REQ-032 rst_n=0 -> out_valid=4'b0000, out_data=0, stat_cnt=0, in_ready=1, asynchronously.
REQ-033 push 16'hE1D8, sel=01, out_ready=0 -> next cycle out_valid=4'b0010, ch1 data=16'hE1D8, ch0/ch2/ch3 data=0.
REQ-034 sel=10 pushes 16'h1111,16'h2222, out_ready[2]=0 -> in_ready=0 with sel=10; pulse out_ready[2] one cycle -> 16'h1111 popped, in_ready=1 next cycle, head=16'h2222.
REQ-035 ch3 full, out_ready[3]=1 and in_valid sel=11 same cycle -> in_ready=0, one pop, next cycle count=1, then push accepted.
REQ-036 back-to-back sel 00,01,10,11 with 16'hAAAA,16'hBBBB,16'hCCCC,16'hDDDD, out_ready=4'b1111 -> each word on its channel exactly one cycle after acceptance, in_ready held 1.
REQ-037 DMUX4_STATS_EN defined, 3 pops on ch0 -> stat_cnt[15:0]=3; rst_n pulse -> 0; macro undefined -> stat_cnt=0 throughout.
